blk_mem_arbiter: RTL and testbench
==================================

Name: blk_mem_arbiter

Overview:
- Shares the single block-transfer memory port between the instruction-cache refill path and the data-cache refill and write-back paths.
- Sits between the future I-cache/D-cache controllers and the top-level block pins (iBlkRead/dBlkRead/dBlkWrite, block_read_fDM, block_write_2DM, *_valid).
- Serialises transfers with fixed priority and I-side anti-starvation, and returns registered data plus a one-cycle done pulse to each requester.

Parameters:
- STARVE_LIMIT, 16: consecutive cycles an I-read may wait in IDLE before it beats D-side requests.
- ADDR_W, 32: address width.
- BLK_W, 256: block width in bits.

Ports:
- CLK  in  1  clock; all state changes on posedge.
- RESET  in  1  asynchronous, active-low reset.
- i_rd_req  in  1  I-cache block read request; level, held until i_done.
- i_addr  in  ADDR_W  I-read block address; stable while i_rd_req is high.
- i_done  out  1  one-cycle pulse: I-read complete, i_rdata valid.
- i_rdata  out  BLK_W  registered I-read block.
- d_rd_req  in  1  D-cache block read request.
- d_wr_req  in  1  D-cache write-back request.
- d_addr  in  ADDR_W  D-side block address.
- d_wdata  in  BLK_W  write-back block; stable while d_wr_req is high.
- d_done  out  1  one-cycle pulse: D transfer (read or write) complete.
- d_rdata  out  BLK_W  registered D-read block.
- mem_addr  out  ADDR_W  address to memory.
- mem_rd  out  1  block read strobe to memory.
- mem_wr  out  1  block write strobe to memory.
- mem_wdata  out  BLK_W  block write data to memory.
- mem_rdata  in  BLK_W  block read data from memory.
- mem_rd_valid  in  1  memory read complete.
- mem_wr_valid  in  1  memory write complete.
- busy  out  1  high in any non-IDLE state.

Behaviour:
- Reset (RESET=0, async): state=IDLE; all outputs 0, including i_rdata, d_rdata, mem_addr and mem_wdata; starvation counter=0.
- States: IDLE, I_RD, D_RD, D_WR, RESP_I, RESP_D.
- IDLE arbitration, evaluated each cycle, first match wins:
  1. i_rd_req && cnt==STARVE_LIMIT -> I_RD.
  2. d_wr_req -> D_WR.
  3. d_rd_req -> D_RD.
  4. i_rd_req -> I_RD.
- Simultaneous d_wr_req and d_rd_req: the write goes first (write-back precedes refill).
- On the grant edge: mem_addr/mem_wdata captured from the winner's inputs into registers. In I_RD/D_RD, mem_rd=1; in D_WR, mem_wr=1. Strobes are held until the matching valid.
- I_RD/D_RD: on mem_rd_valid=1, latch mem_rdata into i_rdata/d_rdata, go to RESP_I/RESP_D, mem_rd=0 on the same edge.
- D_WR: on mem_wr_valid=1 -> RESP_D, mem_wr=0.
- Valid of the wrong type (e.g. mem_wr_valid in I_RD) is ignored.
- RESP_x: done pulse high for exactly this one cycle; no arbitration; always -> IDLE next edge. The requester drops its req during RESP_x.
- Latency: grant edge G; if valid is seen in cycle M, done is high in cycle M+1. Earliest next grant is the edge ending cycle M+2. Minimum 3 cycles per transfer (valid in first busy cycle).
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) on every IDLE-cycle edge where i_rd_req=1 and a D request wins.
  - Clears when I_RD is granted or when i_rd_req=0.
  - Holds outside IDLE.
- A request deasserted mid-transfer does not abort it: the transfer completes and done still pulses.
- RESET asserted mid-transfer: immediate return to IDLE with the reset values above; no done pulse.
- busy = (state != IDLE).
- Only one of mem_rd/mem_wr is ever high; i_done and d_done are never high together.

Test Plan:
- Single I-read, i_addr=0x0040_0020, memory returns 0xAB..AB with mem_rd_valid 2 cycles after mem_rd rises -> mem_addr=0x0040_0020; i_done one cycle after valid with i_rdata=0xAB..AB; busy falls next cycle.
- d_wr_req and d_rd_req raised in the same cycle, addr 0x1000_0040, each valid after 1 cycle -> D_WR first (mem_wr, mem_wdata=d_wdata), d_done; then D_RD, second d_done; order checked.
- i_rd_req held while D requests are continuously re-raised for 20 transfers -> I_RD granted no later than the 17th arbitration (STARVE_LIMIT=16); counter clears afterwards.
- mem_wr_valid pulsed during I_RD -> ignored, state stays I_RD; completes only on mem_rd_valid.
- RESET driven low while in D_RD with mem_rd=1 -> mem_rd=0 and busy=0 immediately (async, before the next edge), no d_done; after release a new i_rd_req is served normally.
- Back-to-back I-reads with requester re-raising i_rd_req right after i_done, memory valid in the first busy cycle -> one transfer every 3 cycles; i_done never stuck high.

Source files
------------

// File: rtl/blk_mem_arbiter.sv
// blk_mem_arbiter: serialises I-refill, D-refill and D-write-back block transfers onto one memory port.
// Fixed priority (write-back > D-refill > I-refill) with a starvation override for the I side.
module blk_mem_arbiter #(
    parameter int STARVE_LIMIT = 16,
    parameter int ADDR_W       = 32,
    parameter int BLK_W        = 256
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [BLK_W-1:0]  i_rdata,
    input  logic              d_rd_req,
    input  logic              d_wr_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [BLK_W-1:0]  d_wdata,
    output logic              d_done,
    output logic [BLK_W-1:0]  d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [BLK_W-1:0]  mem_wdata,
    input  logic [BLK_W-1:0]  mem_rdata,
    input  logic              mem_rd_valid,
    input  logic              mem_wr_valid,
    output logic              busy
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_WR, RESP_I, RESP_D} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BLK_W-1:0]  wdata_q, wdata_d;
    logic [BLK_W-1:0]  i_rdata_q, i_rdata_d;
    logic [BLK_W-1:0]  d_rdata_q, d_rdata_d;
    logic              starved, grant;

    assign starved = i_rd_req && cnt_q == CW'(STARVE_LIMIT);
    assign grant   = state_q == IDLE && state_d != IDLE;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = starved ? I_RD : d_wr_req ? D_WR : d_rd_req ? D_RD : i_rd_req ? I_RD : IDLE;
            I_RD:    state_d = mem_rd_valid ? RESP_I : I_RD;
            D_RD:    state_d = mem_rd_valid ? RESP_D : D_RD;
            D_WR:    state_d = mem_wr_valid ? RESP_D : D_WR;
            default: state_d = IDLE;
        endcase
    end

    // a waiting I-read with no I grant this cycle means a D request won
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE)
            cnt_d = (!i_rd_req || state_d == I_RD) ? '0 :
                    (cnt_q == CW'(STARVE_LIMIT)) ? cnt_q : cnt_q + CW'(1);
        addr_d    = grant ? (state_d == I_RD ? i_addr : d_addr) : addr_q;
        wdata_d   = (grant && state_d == D_WR) ? d_wdata : wdata_q;
        i_rdata_d = (state_q == I_RD && mem_rd_valid) ? mem_rdata : i_rdata_q;
        d_rdata_d = (state_q == D_RD && mem_rd_valid) ? mem_rdata : d_rdata_q;
    end

    always_comb begin
        mem_rd    = state_q == I_RD || state_q == D_RD;
        mem_wr    = state_q == D_WR;
        i_done    = state_q == RESP_I;
        d_done    = state_q == RESP_D;
        busy      = state_q != IDLE;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        i_rdata   = i_rdata_q;
        d_rdata   = d_rdata_q;
    end
endmodule

// File: tb/tb_blk_mem_arbiter.sv
// tb_blk_mem_arbiter: table vectors, directed corner sequences and a randomized
// transaction-level reference model for blk_mem_arbiter.
module tb_blk_mem_arbiter;
    localparam int LIM = 16;
    localparam int AW  = 32;
    localparam int BW  = 256;
    localparam logic [AW-1:0] IA = 32'h0040_0020;
    localparam logic [AW-1:0] DA = 32'h1000_0040;

    logic          CLK = 1'b0, RESET = 1'b0;
    logic          i_rd_req = 0, d_rd_req = 0, d_wr_req = 0;
    logic [AW-1:0] i_addr = '0, d_addr = '0, mem_addr;
    logic [BW-1:0] d_wdata = '0, mem_rdata = '0, i_rdata, d_rdata, mem_wdata;
    logic          mem_rd_valid = 0, mem_wr_valid = 0;
    logic          i_done, d_done, mem_rd, mem_wr, busy;

    int total = 0, bad = 0;

    blk_mem_arbiter #(.STARVE_LIMIT(LIM), .ADDR_W(AW), .BLK_W(BW)) dut (
        .CLK(CLK), .RESET(RESET),
        .i_rd_req(i_rd_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .d_rd_req(d_rd_req), .d_wr_req(d_wr_req), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_rd_valid(mem_rd_valid), .mem_wr_valid(mem_wr_valid),
        .busy(busy)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] rnd_blk();
        logic [BW-1:0] b;
        for (int k = 0; k < BW / 32; k++) b[k*32 +: 32] = $urandom;
        return b;
    endfunction

    typedef struct {
        logic i, dr, dw;
        int   dly;
        logic e_rd, e_wr, e_id, e_dd;
        logic [AW-1:0] e_addr;
    } vec_t;
    vec_t vt[7];

    initial begin
        logic [BW-1:0] rd_blk, wd_blk;
        int n_arb, got_i, last, n_done;
        // reset state
        repeat (2) @(negedge CLK);
        chk("rst_ctl", {i_done, d_done, mem_rd, mem_wr, busy}, '0);
        chk("rst_addr", mem_addr, '0);
        chk("rst_wdata", mem_wdata, '0);
        chk("rst_irdata", i_rdata, '0);
        chk("rst_drdata", d_rdata, '0);
        RESET = 1'b1;
        @(negedge CLK);
        chk("idle_busy", busy, 0);

        // table: single arbitration from IDLE with zero starvation history
        vt[0] = '{1, 0, 0, 0, 1, 0, 1, 0, IA};
        vt[1] = '{0, 1, 0, 1, 1, 0, 0, 1, DA};
        vt[2] = '{0, 0, 1, 2, 0, 1, 0, 1, DA};
        vt[3] = '{0, 1, 1, 0, 0, 1, 0, 1, DA};
        vt[4] = '{1, 1, 0, 1, 1, 0, 0, 1, DA};
        vt[5] = '{1, 0, 1, 0, 0, 1, 0, 1, DA};
        vt[6] = '{1, 1, 1, 3, 0, 1, 0, 1, DA};
        i_addr = IA;
        d_addr = DA;
        for (int v = 0; v < 7; v++) begin
            rd_blk = rnd_blk();
            wd_blk = rnd_blk();
            mem_rdata = rd_blk;
            d_wdata = wd_blk;
            {i_rd_req, d_rd_req, d_wr_req} = {vt[v].i, vt[v].dr, vt[v].dw};
            @(negedge CLK);
            chk($sformatf("vec%0d_strobe", v), {busy, mem_rd, mem_wr}, {1'b1, vt[v].e_rd, vt[v].e_wr});
            chk($sformatf("vec%0d_addr", v), mem_addr, vt[v].e_addr);
            if (vt[v].e_wr) chk($sformatf("vec%0d_wdata", v), mem_wdata, wd_blk);
            repeat (vt[v].dly) @(negedge CLK);
            {mem_rd_valid, mem_wr_valid} = {vt[v].e_rd, vt[v].e_wr};
            @(negedge CLK);
            chk($sformatf("vec%0d_done", v), {i_done, d_done}, {vt[v].e_id, vt[v].e_dd});
            if (vt[v].e_id) chk($sformatf("vec%0d_irdata", v), i_rdata, rd_blk);
            if (vt[v].e_dd && vt[v].e_rd) chk($sformatf("vec%0d_drdata", v), d_rdata, rd_blk);
            {i_rd_req, d_rd_req, d_wr_req, mem_rd_valid, mem_wr_valid} = '0;
            @(negedge CLK);
            chk($sformatf("vec%0d_idle", v), {busy, i_done, d_done}, '0);
        end

        // single I-read, valid in the third busy cycle
        mem_rdata = {32{8'hAB}};
        i_rd_req = 1;
        @(negedge CLK);
        chk("tp1_rd", {mem_rd, mem_wr}, 2'b10);
        chk("tp1_addr", mem_addr, IA);
        repeat (2) @(negedge CLK);
        chk("tp1_wait", {mem_rd, i_done}, 2'b10);
        mem_rd_valid = 1;
        @(negedge CLK);
        chk("tp1_done", {i_done, d_done, busy, mem_rd}, 4'b1010);
        chk("tp1_data", i_rdata, {32{8'hAB}});
        {mem_rd_valid, i_rd_req} = '0;
        @(negedge CLK);
        chk("tp1_idle", {busy, i_done}, 2'b00);

        // simultaneous D write-back and refill: write first
        wd_blk = rnd_blk();
        rd_blk = rnd_blk();
        d_wdata = wd_blk;
        mem_rdata = rd_blk;
        {d_wr_req, d_rd_req} = 2'b11;
        @(negedge CLK);
        chk("tp2_wr_first", {mem_wr, mem_rd}, 2'b10);
        chk("tp2_wdata", mem_wdata, wd_blk);
        mem_wr_valid = 1;
        @(negedge CLK);
        chk("tp2_wdone", {d_done, i_done}, 2'b10);
        {mem_wr_valid, d_wr_req} = '0;
        @(negedge CLK);
        chk("tp2_gap", {busy, d_done}, 2'b00);
        @(negedge CLK);
        chk("tp2_rd_second", {mem_wr, mem_rd}, 2'b01);
        chk("tp2_addr", mem_addr, DA);
        mem_rd_valid = 1;
        @(negedge CLK);
        chk("tp2_rdone", d_done, 1);
        chk("tp2_rdata", d_rdata, rd_blk);
        {mem_rd_valid, d_rd_req} = '0;
        @(negedge CLK);

        // starvation: I held while D refills keep winning
        i_rd_req = 1;
        d_rd_req = 1;
        got_i = 0;
        n_arb = 0;
        while (!got_i && n_arb < 20) begin
            n_arb++;
            @(negedge CLK);
            got_i = (mem_addr == IA);
            mem_rd_valid = 1;
            @(negedge CLK);
            mem_rd_valid = 0;
            if (got_i) i_rd_req = 0;
            else d_rd_req = 0;
            @(negedge CLK);
            d_rd_req = 1;
        end
        chk("starve_grant_at", n_arb, 17);
        i_rd_req = 1;
        @(negedge CLK);
        chk("starve_cleared", mem_addr, DA);
        mem_rd_valid = 1;
        @(negedge CLK);
        {mem_rd_valid, d_rd_req} = '0;
        @(negedge CLK);
        @(negedge CLK);
        chk("starve_then_i", mem_addr, IA);
        mem_rd_valid = 1;
        @(negedge CLK);
        {mem_rd_valid, i_rd_req} = '0;
        @(negedge CLK);

        // wrong-type valid ignored in I_RD
        rd_blk = rnd_blk();
        mem_rdata = rd_blk;
        i_rd_req = 1;
        @(negedge CLK);
        mem_wr_valid = 1;
        @(negedge CLK);
        chk("wrongvalid_hold", {busy, mem_rd, i_done, d_done}, 4'b1100);
        mem_wr_valid = 0;
        mem_rd_valid = 1;
        @(negedge CLK);
        chk("wrongvalid_done", {i_done, d_done}, 2'b10);
        chk("wrongvalid_data", i_rdata, rd_blk);
        {mem_rd_valid, i_rd_req} = '0;
        @(negedge CLK);

        // async reset while in D_RD
        d_rd_req = 1;
        @(negedge CLK);
        chk("rstmid_pre", mem_rd, 1);
        RESET = 0;
        #1;
        chk("rstmid_async", {mem_rd, busy, d_done}, 3'b000);
        chk("rstmid_regs", {mem_addr, d_rdata}, '0);
        d_rd_req = 0;
        mem_rd_valid = 1;
        @(negedge CLK);
        chk("rstmid_nodone", {d_done, busy}, 2'b00);
        mem_rd_valid = 0;
        RESET = 1;
        @(negedge CLK);
        rd_blk = rnd_blk();
        mem_rdata = rd_blk;
        i_rd_req = 1;
        @(negedge CLK);
        chk("rstmid_after", {mem_rd, mem_addr}, {1'b1, IA});
        mem_rd_valid = 1;
        @(negedge CLK);
        chk("rstmid_after_done", {i_done, i_rdata}, {1'b1, rd_blk});
        {mem_rd_valid, i_rd_req} = '0;
        @(negedge CLK);

        // back-to-back I-reads, memory answers in the first busy cycle
        last = -1;
        n_done = 0;
        for (int k = 0; k < 15; k++) begin
            if (i_done) begin
                if (last >= 0) chk("b2b_period", k - last, 3);
                last = k;
                n_done++;
            end
            mem_rd_valid = mem_rd;
            i_rd_req = !i_done;
            @(negedge CLK);
            if (k > 0 && i_done && last == k) chk("b2b_not_stuck", i_done, 0);
        end
        chk("b2b_count", n_done, 5);
        chk("b2b_idle", busy, 0);
        {mem_rd_valid, i_rd_req} = '0;
        @(negedge CLK);

        rand_phase(60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // transaction-level model: each IDLE cycle is one arbitration; waiting I
    // tracks how many D grants in a row it has lost
    task automatic rand_phase(input int n);
        int lost = 0, win, dly;
        logic ip = 0, drp = 0, dwp = 0;
        logic [AW-1:0] ia = '0, da = '0;
        logic [BW-1:0] wd = '0, rd = '0;
        for (int t = 0; t < n; t++) begin
            if (!ip && $urandom_range(0, 1) == 1) begin ip = 1; ia = $urandom; end
            if (!drp && !dwp) da = $urandom;
            if (!drp && $urandom_range(0, 3) != 0) drp = 1;
            if (!dwp && $urandom_range(0, 2) == 0) begin dwp = 1; wd = rnd_blk(); end
            if (!ip && !drp && !dwp) begin ip = 1; ia = $urandom; end
            {i_rd_req, d_rd_req, d_wr_req} = {ip, drp, dwp};
            i_addr = ia;
            d_addr = da;
            d_wdata = wd;
            win = (ip && lost == LIM) ? 0 : dwp ? 2 : drp ? 1 : 0;
            lost = (!ip || win == 0) ? 0 : (lost < LIM ? lost + 1 : LIM);
            dly = $urandom_range(0, 3);
            rd = rnd_blk();
            mem_rdata = rd;
            @(negedge CLK);
            chk("rnd_strobe", {busy, mem_rd, mem_wr}, {1'b1, win != 2, win == 2});
            chk("rnd_addr", mem_addr, win == 0 ? ia : da);
            if (win == 2) chk("rnd_wdata", mem_wdata, wd);
            for (int k = 0; k < dly; k++) begin
                mem_wr_valid = (win != 2) && $urandom_range(0, 1) == 1;
                mem_rd_valid = (win == 2) && $urandom_range(0, 1) == 1;
                @(negedge CLK);
                chk("rnd_hold", {busy, i_done, d_done}, 3'b100);
            end
            mem_rd_valid = win != 2;
            mem_wr_valid = win == 2;
            @(negedge CLK);
            chk("rnd_done", {i_done, d_done}, {win == 0, win != 0});
            if (win == 0) chk("rnd_irdata", i_rdata, rd);
            if (win == 1) chk("rnd_drdata", d_rdata, rd);
            if (win == 0) ip = 0;
            if (win == 1) drp = 0;
            if (win == 2) dwp = 0;
            {i_rd_req, d_rd_req, d_wr_req} = {ip, drp, dwp};
            {mem_rd_valid, mem_wr_valid} = '0;
            @(negedge CLK);
            chk("rnd_idle", {busy, i_done, d_done}, 3'b000);
        end
        {i_rd_req, d_rd_req, d_wr_req} = '0;
    endtask
endmodule
